// File: rtl/sar_comp_responder.sv
// -----------------------------------------------------------------------------
// sar_comp_responder
//
// Behavioural stand-in for the sample-and-hold plus comparator front end of a
// successive-approximation ADC. A sample is accepted in IDLE and then settles
// for SETTLE cycles in ACQUIRE. In HOLD, every trial code presented by the SAR
// engine is compared against the held value. The result comes out through a
// LAT-deep pipeline. eoc ends the conversion and drops any result still in
// flight.
//
// Parameters
//   WIDTH   code width of the sampled value and of trial codes
//   LAT     comparator latency in cycles (1..8)
//   SETTLE  acquisition cycles after a sample is accepted (1..15)
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   vin_data     unsigned input-voltage code to be sampled
//   vin_valid    vin_data offered
//   vin_ready    sample accepted this cycle if vin_valid (IDLE only)
//   trial_code   SAR trial code
//   trial_valid  trial_code valid this cycle
//   eoc          end of conversion; releases the hold
//   comp_out     comparator result, 1 = held_value >= trial_code
//   comp_valid   one-cycle strobe marking a new comp_out
//   busy         high in ACQUIRE and HOLD
//   held_value   currently held sample
//   proto_err    sticky flag: trial_valid outside HOLD
// -----------------------------------------------------------------------------
module sar_comp_responder #(
    parameter int WIDTH  = 10,
    parameter int LAT    = 2,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] vin_data,
    input  logic             vin_valid,
    output logic             vin_ready,
    input  logic [WIDTH-1:0] trial_code,
    input  logic             trial_valid,
    input  logic             eoc,
    output logic             comp_out,
    output logic             comp_valid,
    output logic             busy,
    output logic [WIDTH-1:0] held_value,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    // SETTLE is at most 15, so four bits always hold the acquisition count.
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t           state_q;
    logic [3:0]       settle_q;
    logic [WIDTH-1:0] held_q;
    logic             proto_err_q;

    // Pipeline: bit i of vpipe_q marks a live result in stage i, and bit i of
    // dpipe_q carries that result. The last stage drives comp_valid/comp_out.
    logic [LAT-1:0]   vpipe_q;
    logic [LAT-1:0]   dpipe_q;
    logic [LAT-1:0]   vpipe_d;
    logic [LAT-1:0]   dpipe_d;

    logic             launch;
    logic             flush;
    logic             cmp_ge;

    // A trial that arrives in the same cycle as eoc is ignored. eoc in HOLD
    // drops every in-flight result, so no strobe comes from them.
    assign flush  = (state_q == S_HOLD) && eoc;
    assign launch = (state_q == S_HOLD) && trial_valid && !eoc;
    assign cmp_ge = (held_q >= trial_code);

    // -------------------------------------------------------------------------
    // Control FSM: state, acquisition counter, held sample, sticky error.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            settle_q    <= '0;
            held_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register in this block sees pre-edge values of the others.
            if (trial_valid && (state_q != S_HOLD)) begin
                proto_err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (vin_valid) begin
                        held_q   <= vin_data;
                        settle_q <= SETTLE_LD;
                        state_q  <= S_ACQUIRE;
                    end
                end
                S_ACQUIRE: begin
                    // The counter is loaded with SETTLE on accept and reaches
                    // 1 on the last of exactly SETTLE ACQUIRE cycles.
                    settle_q <= settle_q - 4'd1;
                    if (settle_q == 4'd1) begin
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (eoc) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Comparator pipeline: stage 0 takes a new launch, stage g takes stage g-1.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < LAT; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign vpipe_d[g] = launch;
            assign dpipe_d[g] = cmp_ge;
        end else begin : g_body
            assign vpipe_d[g] = vpipe_q[g-1];
            assign dpipe_d[g] = dpipe_q[g-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe_q <= '0;
            // NOTE: the data lanes are reset as well as the valid bits because
            // the last lane is comp_out itself, which must read 0 after reset.
            dpipe_q <= '0;
        end else begin
            vpipe_q <= flush ? '0 : vpipe_d;
            // A data lane loads only when a live result enters it. The last
            // lane therefore holds the most recent completed result between
            // strobes, and a flushed result never reaches comp_out.
            for (int i = 0; i < LAT; i++) begin
                if (vpipe_d[i] && !flush) begin
                    dpipe_q[i] <= dpipe_d[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign vin_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign held_value = held_q;
    assign proto_err  = proto_err_q;
    assign comp_valid = vpipe_q[LAT-1];
    assign comp_out   = dpipe_q[LAT-1];

endmodule

// File: doc/sar_comp_responder.md
SAR_COMP_RESPONDER -- requirements
Module: sar_comp_responder

Interface
REQ-001 Parameter WIDTH, default 10, code width of sampled value and trial codes.
REQ-002 Parameter LAT, default 2, comparator latency in cycles; legal range 1..8.
REQ-003 Parameter SETTLE, default 4, acquisition cycles after sample accept; legal range 1..15.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 vin_data  input  WIDTH  unsigned input-voltage code to be sampled.
REQ-007 vin_valid  input  1  vin_data offered.
REQ-008 vin_ready  output  1  responder will accept a sample this cycle.
REQ-009 trial_code  input  WIDTH  SAR trial code for comparison.
REQ-010 trial_valid  input  1  trial_code valid this cycle.
REQ-011 eoc  input  1  end-of-conversion from SAR; releases the hold.
REQ-012 comp_out  output  1  comparator result, 1 = held value >= trial code.
REQ-013 comp_valid  output  1  one-cycle strobe marking a new comp_out.
REQ-014 busy  output  1  high in ACQUIRE and HOLD.
REQ-015 held_value  output  WIDTH  currently held sample.
REQ-016 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-017 States: IDLE, ACQUIRE, HOLD; reset state IDLE.
REQ-018 vin_ready shall be 1 only in IDLE; sample accepted on cycle with vin_valid && vin_ready.
REQ-019 On accept: held_value <= vin_data, settle counter loaded, next state ACQUIRE.
REQ-020 ACQUIRE shall last exactly SETTLE cycles, then HOLD; held_value shall not change outside the accept cycle.
REQ-021 In HOLD, each cycle with trial_valid shall launch one comparison, result = (held_value >= trial_code), unsigned, full WIDTH.
REQ-022 Result shall appear on comp_out with comp_valid=1 exactly LAT cycles after the launching edge; back-to-back trials every cycle supported (LAT-deep pipeline).
REQ-023 comp_out shall hold its last value between strobes; comp_valid shall be 0 when no result completes.
REQ-024 eoc in HOLD: next state IDLE; all in-flight comparisons discarded (no comp_valid for them); trial_valid on the same cycle as eoc is ignored.
REQ-025 eoc outside HOLD shall be ignored and shall not set proto_err.
REQ-026 trial_valid in IDLE or ACQUIRE shall launch nothing and shall set proto_err.
REQ-027 proto_err cleared only by reset.
REQ-028 busy = (state != IDLE), combinational from state.
REQ-029 Boundaries: trial_code == held_value -> 1; trial all-zero -> 1; held all-zero with nonzero trial -> 0; held all-ones -> 1 for any trial.

Reset
REQ-030 rst asserted at any time, including mid-ACQUIRE or with comparisons in flight, shall force IDLE, clear pipeline, with no comp_valid strobe emerging after deassertion.
REQ-031 Reset values: vin_ready=1, comp_out=0, comp_valid=0, busy=0, held_value=0, proto_err=0.

Verification
REQ-032 Sample 0x200, after SETTLE=4 trials 0x200, 0x300, 0x180 on consecutive cycles -> comp_out 1,0,1 with comp_valid at launch+2, +3, +4 (LAT=2).
REQ-033 Full 10-bit SAR loop driven by bench against held 0x2A5 -> final code 0x2A5 in 10 trials, proto_err=0.
REQ-034 trial_valid one cycle after accept (ACQUIRE) -> no comp_valid, proto_err=1 and stays 1.
REQ-035 Trials launched, eoc asserted 1 cycle later (LAT=2) -> no comp_valid for either trial, vin_ready=1 next cycle.
REQ-036 rst pulsed mid-HOLD with 2 trials in flight -> all outputs at reset values, no strobe afterward; new sample 0x3FF then trial 0x3FF -> comp_out=1.
REQ-037 Held 0x000, trial 0x001 -> 0; trial 0x000 -> 1; vin_valid during HOLD -> not accepted, held_value unchanged.
